// File: rtl/risc_pkg.sv
// ============================================================================
//  Module      : risc_pkg
//  Description : Shared RV32I ALU op encoding, opcodes and issue packet type.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package risc_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        alu_op_t     op;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } issue_pkt_t;

endpackage

`default_nettype wire

// File: rtl/alu_decode.sv
// ============================================================================
//  Module      : alu_decode
//  Description : Combinational RV32I integer-ALU decode into an issue packet.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_decode
    import risc_pkg::*;
(
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    output issue_pkt_t  o_pkt
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_u;
    logic [31:0] w_shamt;

    logic        w_legal;
    alu_op_t     w_op;
    logic [31:0] w_a;
    logic [31:0] w_b;

    assign w_opcode = i_instr[6:0];
    assign w_rd     = i_instr[11:7];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];
    assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_u  = {i_instr[31:12], 12'h000};
    assign w_shamt  = {27'd0, i_instr[24:20]};

    always_comb begin
        w_legal = 1'b1;
        w_op    = ALU_ADD;
        w_a     = 32'd0;
        w_b     = 32'd0;
        case (w_opcode)
            OPC_OP: begin
                w_a = i_rs1_data;
                w_b = i_rs2_data;
                if (w_funct7 == F7_BASE) begin
                    case (w_funct3)
                        3'b000:  w_op = ALU_ADD;
                        3'b001:  w_op = ALU_SLL;
                        3'b010:  w_op = ALU_SLT;
                        3'b011:  w_op = ALU_SLTU;
                        3'b100:  w_op = ALU_XOR;
                        3'b101:  w_op = ALU_SRL;
                        3'b110:  w_op = ALU_OR;
                        default: w_op = ALU_AND;
                    endcase
                end else if (w_funct7 == F7_ALT && w_funct3 == 3'b000) begin
                    w_op = ALU_SUB;
                end else if (w_funct7 == F7_ALT && w_funct3 == 3'b101) begin
                    w_op = ALU_SRA;
                end else begin
                    w_legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                w_a = i_rs1_data;
                w_b = w_imm_i;
                case (w_funct3)
                    3'b000: w_op = ALU_ADD;
                    3'b010: w_op = ALU_SLT;
                    3'b011: w_op = ALU_SLTU;
                    3'b100: w_op = ALU_XOR;
                    3'b110: w_op = ALU_OR;
                    3'b111: w_op = ALU_AND;
                    3'b001: begin
                        w_b     = w_shamt;
                        w_op    = ALU_SLL;
                        w_legal = (w_funct7 == F7_BASE);
                    end
                    default: begin
                        // funct3 101: funct7 picks logical vs arithmetic shift
                        w_b = w_shamt;
                        if (w_funct7 == F7_BASE) begin
                            w_op = ALU_SRL;
                        end else if (w_funct7 == F7_ALT) begin
                            w_op = ALU_SRA;
                        end else begin
                            w_legal = 1'b0;
                        end
                    end
                endcase
            end
            OPC_LUI: begin
                w_b = w_imm_u;
            end
            OPC_AUIPC: begin
                w_a = i_pc;
                w_b = w_imm_u;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase

        if (!w_legal) begin
            w_op = ALU_ADD;
            w_a  = 32'd0;
            w_b  = 32'd0;
        end
    end

    always_comb begin
        o_pkt         = '0;
        o_pkt.a       = w_a;
        o_pkt.b       = w_b;
        o_pkt.op      = w_op;
        o_pkt.rd      = w_rd;
        o_pkt.rd_we   = w_legal && (w_rd != 5'd0);
        o_pkt.illegal = !w_legal;
    end

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// ============================================================================
//  Module      : alu_issue_stage
//  Description : RV32I ALU decode/issue stage with a 2-entry skid pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_issue_stage
    import risc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_alu_a,
    output logic [31:0] out_alu_b,
    output alu_op_t     out_alu_op,
    output logic [4:0]  out_rd,
    output logic        out_rd_we,
    output logic        out_illegal
);

    issue_pkt_t w_dec_pkt;
    logic       w_accept;

    logic       r_main_valid_q, w_main_valid_d;
    issue_pkt_t r_main_pkt_q,   w_main_pkt_d;
    logic       r_skid_valid_q, w_skid_valid_d;
    issue_pkt_t r_skid_pkt_q,   w_skid_pkt_d;
    logic       r_in_ready_q,   w_in_ready_d;

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    alu_decode u_decode (
        .i_instr    (in_instr),
        .i_pc       (in_pc),
        .i_rs1_data (rs1_data),
        .i_rs2_data (rs2_data),
        .o_pkt      (w_dec_pkt)
    );

    assign w_accept = in_valid && r_in_ready_q && !flush;

    // A full skid always holds in_ready low, so no accept can coincide with
    // a skid-to-main transfer.
    always_comb begin
        w_main_valid_d = r_main_valid_q;
        w_main_pkt_d   = r_main_pkt_q;
        w_skid_valid_d = r_skid_valid_q;
        w_skid_pkt_d   = r_skid_pkt_q;
        if (flush) begin
            w_main_valid_d = 1'b0;
            w_skid_valid_d = 1'b0;
        end else if (!r_main_valid_q || out_ready) begin
            if (r_skid_valid_q) begin
                w_main_valid_d = 1'b1;
                w_main_pkt_d   = r_skid_pkt_q;
                w_skid_valid_d = 1'b0;
            end else begin
                w_main_valid_d = w_accept;
                if (w_accept) begin
                    w_main_pkt_d = w_dec_pkt;
                end
            end
        end else if (w_accept) begin
            w_skid_valid_d = 1'b1;
            w_skid_pkt_d   = w_dec_pkt;
        end
        w_in_ready_d = !w_skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid_q <= 1'b0;
            r_main_pkt_q   <= '0;
            r_skid_valid_q <= 1'b0;
            r_skid_pkt_q   <= '0;
            r_in_ready_q   <= 1'b1;
        end else begin
            r_main_valid_q <= w_main_valid_d;
            r_main_pkt_q   <= w_main_pkt_d;
            r_skid_valid_q <= w_skid_valid_d;
            r_skid_pkt_q   <= w_skid_pkt_d;
            r_in_ready_q   <= w_in_ready_d;
        end
    end

    assign in_ready    = r_in_ready_q;
    assign out_valid   = r_main_valid_q;
    assign out_alu_a   = r_main_pkt_q.a;
    assign out_alu_b   = r_main_pkt_q.b;
    assign out_alu_op  = r_main_pkt_q.op;
    assign out_rd      = r_main_pkt_q.rd;
    assign out_rd_we   = r_main_pkt_q.rd_we;
    assign out_illegal = r_main_pkt_q.illegal;

endmodule

`default_nettype wire

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode and issue stage that feeds the ALU. It accepts fetched instructions over a valid/ready handshake and decodes the RV32I integer-ALU subset (OP, OP-IMM, LUI, AUIPC) into `alu_op_t`, operand A and operand B. It registers the result into a 2-entry skid-buffered pipeline register whose outputs drive `alu_a`, `alu_b` and `alu_op` in the execute stage. It also drives the register-file read addresses and carries destination-register information downstream.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  synchronous pipeline flush; discards all held entries.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  stage can accept; registered.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  32  instruction address.
- `rs1_addr`  out  5  combinational, equal to `in_instr[19:15]`.
- `rs2_addr`  out  5  combinational, equal to `in_instr[24:20]`.
- `rs1_data`  in  32  register-file read data for `rs1_addr`, same cycle; x0 reads as 0.
- `rs2_data`  in  32  register-file read data for `rs2_addr`, same cycle.
- `out_valid`  out  1  issued entry present.
- `out_ready`  in  1  execute stage accepts.
- `out_alu_a`  out  32  ALU operand A.
- `out_alu_b`  out  32  ALU operand B.
- `out_alu_op`  out  `alu_op_t`  ALU operation.
- `out_rd`  out  5  destination register.
- `out_rd_we`  out  1  write-back enable.
- `out_illegal`  out  1  unsupported encoding.

## Operation
Decode is combinational on `in_instr`, `in_pc` and the read data. Immediates are sign-extended.

- **OP (0110011).**
  - funct7 = 0000000 selects ADD, SLL, SLT, SLTU, XOR, SRL, OR or AND by funct3.
  - funct7 = 0100000 is legal only with funct3 000 (SUB) or 101 (SRA).
  - Operands: a = `rs1_data`, b = `rs2_data`.
- **OP-IMM (0010011).**
  - funct3 selects ADDI, SLTI, SLTIU, XORI, ORI or ANDI.
  - Operands: a = `rs1_data`, b = sext(`instr[31:20]`).
  - SLLI requires funct7 = 0.
  - SRLI requires funct7 = 0; SRAI requires funct7 = 0100000.
  - For SLLI/SRLI/SRAI, b = zero-extended `instr[24:20]`.
- **LUI (0110111).** Op ADD, a = 0, b = {`instr[31:12]`, 12'b0}.
- **AUIPC (0010111).** Op ADD, a = `in_pc`, b = U-immediate.
- **Anything else** (any other opcode or an illegal funct7):
  - `out_illegal` = 1, op ADD, a = b = 0, `out_rd_we` = 0.
- **Write-back enable.** `out_rd` = `instr[11:7]`. `out_rd_we` = legal && rd ≠ 0.

Buffering uses a main register, which drives the outputs, plus one skid entry.
- **Accept.** An input is accepted when `in_valid && in_ready` and `flush` = 0.
- **Main empty or `out_ready` = 1:**
  - if the skid entry is valid, main loads the skid entry and the skid empties;
  - otherwise main loads the accepted input, or becomes empty if nothing was accepted.
- **Main full, `out_ready` = 0, input accepted:** the decoded input goes to the skid entry.
- **`in_ready`.** Next-state value is !skid_valid_next. It is registered, with no combinational path from `out_ready`.
- **Ordering.** Entries leave strictly in acceptance order; none is dropped or duplicated.

## Timing
- Latency: an instruction accepted in cycle N appears on the outputs in cycle N+1 (`out_valid` = 1).
- Throughput: 1 instruction per cycle while `out_ready` = 1.
- Output stability: while `out_valid && !out_ready`, every `out_*` signal is held stable.
- Reset, `rst` = 1 (highest priority), values from the next edge:
  - `out_valid` = 0, skid empty, `in_ready` = 1;
  - all data outputs = 0, `out_alu_op` = ALU_ADD, `out_illegal` = 0.
- Flush, `flush` = 1 (below reset):
  - clears main and skid valid at the edge; `in_ready` = 1 next cycle;
  - an input presented in the flush cycle is discarded, even if `in_ready` = 1;
  - data registers are not required to clear.
- Simultaneous push and pop with the skid empty: main is replaced by the new entry; no bubble.
- Skid full with `out_ready` = 1: the skid moves to main and `in_ready` returns to 1 the next cycle.

## Structure
- `risc_pkg` is shared with the ALU and holds:
  - `alu_op_t`: ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND;
  - opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC;
  - a packed struct `issue_pkt_t` {a, b, op, rd, rd_we, illegal}.
- One sub-module, `alu_decode`: purely combinational decode of instr, pc and read data into `issue_pkt_t`.
- The skid and main registers stay in `alu_issue_stage`.

## Test plan
- **ADD:** 0x002081B3 (ADD x3,x1,x2) with `rs1_data` = 5, `rs2_data` = 7, `out_ready` = 1 → next cycle a = 5, b = 7, op ALU_ADD, rd = 3, we = 1.
- **Immediates:**
  - 0xFFF00093 (ADDI x1,x0,-1) → b = 0xFFFFFFFF, we = 1;
  - 0x40435293 (SRAI x5,x6,4) → op ALU_SRA, b = 4;
  - 0x123453B7 (LUI x7,0x12345) → a = 0, b = 0x12345000.
- **AUIPC and rd = x0:**
  - 0x00001017 at pc = 0x100 → a = 0x100, b = 0x1000, op ALU_ADD;
  - because rd = 0, `out_rd_we` = 0.
- **Backpressure:** 4 back-to-back valid inputs, `out_ready` low for 3 cycles → `in_ready` falls after 2 accepts; then raise `out_ready` → all 4 emerge in order, no loss or duplication.
- **Flush:** main and skid full, assert `flush` with a new input present → next cycle `out_valid` = 0, `in_ready` = 1, and the flushed and flush-cycle inputs never appear.
- **Illegal and reset:**
  - 0x00000000 → `out_illegal` = 1, we = 0, a = b = 0;
  - 0x40209033 (funct7 0100000, funct3 001) → illegal;
  - `rst` asserted mid-stream → reset values next cycle.
